bus_arb_4t1: RTL and testbench
==============================

BUS_ARB_4T1 -- requirements
Module: bus_arb_4t1

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum number of GRANT cycles without ack before a forced release; legal range 1..255.
REQ-002 Parameter RR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority (req[0] highest).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  4  request lines, one per requester, level-sensitive.
REQ-006 I0, I1, I2, I3  input  32 each  requester payloads (address/data) to the shared 32-bit bus.
REQ-007 ack  input  1  slave completion strobe, one cycle.
REQ-008 gnt  output  4  one-hot grant, registered.
REQ-009 sel  output  2  index of the granted requester, registered; drives the shared 4:1 32-bit bus mux.
REQ-010 o  output  32  shared bus payload: I[sel] while valid=1, else 32'h0 (combinational from registered sel/valid).
REQ-011 valid  output  1  bus cycle in progress, registered.
REQ-012 err  output  1  one-cycle pulse on timeout abort, registered.

Function
REQ-013 The FSM SHALL have two states: IDLE and GRANT.
REQ-014 In IDLE with req==0, the FSM SHALL stay in IDLE with gnt=0, valid=0.
REQ-015 In IDLE with any req bit set at edge N, the block SHALL enter GRANT after edge N with gnt one-hot on the winner, sel=winner index, valid=1, cycle counter=0 (1-cycle grant latency).
REQ-016 With RR=1, the winner SHALL be the first set req bit searching upward from (last+1) mod 4, wrapping 3->0, where last is the most recently granted index.
REQ-017 With RR=0, the winner SHALL be the lowest-indexed set req bit; last is still updated but unused.
REQ-018 In GRANT, gnt, sel and the granted index SHALL remain stable until the FSM leaves GRANT; new requests SHALL NOT preempt.
REQ-019 In GRANT with ack=1 at an edge, the block SHALL return to IDLE after that edge (gnt=0, valid=0) and set last=granted index.
REQ-020 In GRANT with req[granted]=0 and ack=0 at an edge, the block SHALL release to IDLE after that edge, set last=granted index, err=0.
REQ-021 In GRANT, the counter SHALL increment each cycle without ack; when it reaches TIMEOUT-1 without ack, the block SHALL release to IDLE after that edge, set last, and pulse err=1 for exactly one cycle.
REQ-022 Priority at a single edge SHALL be: ack over request-drop over timeout; ack with the timeout condition yields err=0.
REQ-023 After every release, the block SHALL spend exactly one cycle in IDLE (bus turnaround bubble) before any new grant.
REQ-024 ack while in IDLE SHALL be ignored and SHALL NOT change last or raise err.
REQ-025 The counter SHALL be 8 bits and SHALL NOT wrap while in GRANT.
REQ-026 gnt SHALL never have more than one bit set; valid SHALL equal |gnt in every cycle.

Reset
REQ-027 With rst_n=0 at an edge, after that edge: state=IDLE, gnt=4'b0000, sel=2'd0, valid=0, err=0, counter=0, last=2'd3 (req[0] first priority after reset), o=32'h0.
REQ-028 Reset asserted during GRANT SHALL abort the transfer at that edge with no err pulse; req held high across reset SHALL be granted no earlier than 1 cycle after rst_n returns high.

Verification
REQ-029 Reset, then req=4'b0101 held, ack one cycle after each grant -> grant order idx 0, 2, 0, 2 with one IDLE bubble between; o=I0 then I2 while valid.
REQ-030 RR=1, req=4'b1111 held, ack each grant -> sel sequence 0,1,2,3,0 (wrap 3->0); RR=0 same stimulus -> sel always 0.
REQ-031 Grant idx 1, no ack, req held, TIMEOUT=16 -> valid high exactly 16 cycles, err=1 for 1 cycle at release, next grant goes to idx 2 if requesting.
REQ-032 Grant idx 3, ack and req[3] drop in the same cycle, counter at TIMEOUT-1 -> release with err=0, last=3.
REQ-033 rst_n=0 during GRANT of idx 2 -> next cycle gnt=0, valid=0, o=32'h0, err=0; with req=4'b0100 held, re-grant to idx 2 one cycle after rst_n rises.
REQ-034 ack pulsed in IDLE with req=0 -> no state change, err=0; subsequent req=4'b0001 -> grant idx 0.

Source files
------------

// File: rtl/bus_arb_4t1.sv
// 4-requester arbiter driving a shared 32-bit bus, round-robin or fixed priority.
// Latency: grant registered one cycle after a request is seen in IDLE; one IDLE bubble after each release.
// Backpressure: a grant is held until ack, request drop, or TIMEOUT cycles, then released with err on timeout.
module bus_arb_4t1 #(
    parameter int unsigned TIMEOUT = 16,
    parameter bit          RR      = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] I0,
    input  logic [31:0] I1,
    input  logic [31:0] I2,
    input  logic [31:0] I3,
    input  logic        ack,
    output logic [3:0]  gnt,
    output logic [1:0]  sel,
    output logic [31:0] o,
    output logic        valid,
    output logic        err
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last cycle index of a grant before it is forcibly released.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [3:0]  gnt_q;
    logic [1:0]  sel_q;
    logic        valid_q;
    logic        err_q;
    logic [7:0]  cnt_q;
    logic [1:0]  last_q;

    logic [1:0]  win_d;
    logic [1:0]  cand_d;
    logic        found_d;
    logic        release_d;

    // Pick the winner among the current requests: rotating from last+1, or lowest index first.
    always_comb begin
        win_d   = 2'd0;
        cand_d  = 2'd0;
        found_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (RR) begin
                cand_d = last_q + 2'(k + 1);
            end else begin
                cand_d = 2'(k);
            end
            if (!found_d && req[cand_d]) begin
                win_d   = cand_d;
                found_d = 1'b1;
            end
        end
    end

    // A granted transfer ends on ack, on its request dropping, or when the cycle budget is used up.
    always_comb begin
        release_d = ack || !req[sel_q] || (cnt_q == CNT_LAST);
    end

    // Two-state grant FSM; all outputs registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            last_q  <= 2'd3;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= GRANT;
                        gnt_q   <= 4'b0001 << win_d;
                        sel_q   <= win_d;
                        valid_q <= 1'b1;
                        cnt_q   <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        valid_q <= 1'b0;
                        last_q  <= sel_q;
                        // Only a pure timeout flags an error; ack or a dropped request win.
                        err_q   <= !ack && req[sel_q];
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Shared bus mux, forced to zero outside a transfer.
    always_comb begin
        o = 32'h0;
        if (valid_q) begin
            case (sel_q)
                2'd0:    o = I0;
                2'd1:    o = I1;
                2'd2:    o = I2;
                default: o = I3;
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bus_arb_4t1.sv
module tb_bus_arb_4t1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] I0, I1, I2, I3;
    logic        ack;

    logic [3:0]  gnt0, gnt1;
    logic [1:0]  sel0, sel1;
    logic [31:0] o0, o1;
    logic        valid0, valid1, err0, err1;

    int checks = 0;
    int errors = 0;

    // Instance 0: round-robin, TIMEOUT 16. Instance 1: fixed priority, TIMEOUT 4.
    bus_arb_4t1 #(.TIMEOUT(16), .RR(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req(req),
        .I0(I0), .I1(I1), .I2(I2), .I3(I3), .ack(ack),
        .gnt(gnt0), .sel(sel0), .o(o0), .valid(valid0), .err(err0)
    );

    bus_arb_4t1 #(.TIMEOUT(4), .RR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req(req),
        .I0(I0), .I1(I1), .I2(I2), .I3(I3), .ack(ack),
        .gnt(gnt1), .sel(sel1), .o(o1), .valid(valid1), .err(err1)
    );

    always #5 clk = ~clk;

    // Reference model: per instance, who owns the bus, how long, and who was served last.
    int m_tmo  [2] = '{16, 4};
    int m_rr   [2] = '{1, 0};
    int m_busy [2];
    int m_own  [2];
    int m_age  [2];
    int m_last [2];
    int m_err  [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pay(input int idx);
        case (idx)
            0:       return I0;
            1:       return I1;
            2:       return I2;
            default: return I3;
        endcase
    endfunction

    function automatic int pick(input int m, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_rr[m] != 0) ? (m_last[m] + 1 + k) % 4 : k;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic model_edge(input int m);
        m_err[m] = 0;
        if (!rst_n) begin
            m_busy[m] = 0; m_own[m] = 0; m_age[m] = 0; m_last[m] = 3;
        end else if (m_busy[m] != 0) begin
            if (ack) begin
                m_busy[m] = 0; m_last[m] = m_own[m];
            end else if (!req[m_own[m]]) begin
                m_busy[m] = 0; m_last[m] = m_own[m];
            end else if (m_age[m] + 1 >= m_tmo[m]) begin
                m_busy[m] = 0; m_last[m] = m_own[m]; m_err[m] = 1;
            end else begin
                m_age[m]++;
            end
        end else if (req != 4'b0000) begin
            m_own[m] = pick(m, req); m_busy[m] = 1; m_age[m] = 0;
        end
    endtask

    task automatic compare(input int m);
        logic [3:0]  g;
        logic [1:0]  s;
        logic [31:0] ob;
        logic        v, e;
        logic [3:0]  eg;
        string       p;
        g  = (m == 0) ? gnt0 : gnt1;
        s  = (m == 0) ? sel0 : sel1;
        ob = (m == 0) ? o0 : o1;
        v  = (m == 0) ? valid0 : valid1;
        e  = (m == 0) ? err0 : err1;
        p  = (m == 0) ? "rr" : "fp";
        eg = (m_busy[m] != 0) ? (4'b0001 << m_own[m]) : 4'b0000;
        chk({p, "_valid"}, 32'(v), 32'(m_busy[m] != 0));
        chk({p, "_gnt"}, 32'(g), 32'(eg));
        chk({p, "_err"}, 32'(e), 32'(m_err[m]));
        chk({p, "_o"}, ob, (m_busy[m] != 0) ? pay(m_own[m]) : 32'h0);
        if (m_busy[m] != 0) chk({p, "_sel"}, 32'(s), 32'(m_own[m]));
        chk({p, "_onehot"}, 32'($countones(g) <= 1 && v == |g), 32'd1);
    endtask

    // One clock: model advances on the rising edge, DUTs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        compare(0);
        compare(1);
        I0 = $urandom; I1 = $urandom; I2 = $urandom; I3 = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'b0000; ack = 1'b0;
        step();
        chk("rst_sel_rr", 32'(sel0), 32'd0);
        chk("rst_sel_fp", 32'(sel1), 32'd0);
        rst_n = 1'b1;
    endtask

    int got[$];
    int vcnt;
    bit seen_err;

    initial begin
        rst_n = 1'b0; req = 4'b0000; ack = 1'b0;
        I0 = 32'h1000_0000; I1 = 32'h1111_1111; I2 = 32'h2222_2222; I3 = 32'h3333_3333;
        for (int m = 0; m < 2; m++) begin
            m_busy[m] = 0; m_own[m] = 0; m_age[m] = 0; m_last[m] = 3; m_err[m] = 0;
        end
        @(negedge clk);
        do_reset();

        // Two requesters held, ack right after each grant: alternation 0,2,0,2.
        req = 4'b0101; got.delete();
        for (int c = 0; c < 12; c++) begin
            step();
            if (valid0) begin got.push_back(sel0); ack = 1'b1; end
            else ack = 1'b0;
        end
        while (got.size() < 5) got.push_back(7);
        chk("alt_0", 32'(got[0]), 32'd0);
        chk("alt_1", 32'(got[1]), 32'd2);
        chk("alt_2", 32'(got[2]), 32'd0);
        chk("alt_3", 32'(got[3]), 32'd2);

        // All four requesting: rotation with wrap, fixed priority always index 0.
        do_reset();
        req = 4'b1111; got.delete();
        for (int c = 0; c < 12; c++) begin
            step();
            if (valid1) chk("fp_sel_all", 32'(sel1), 32'd0);
            if (valid0) begin got.push_back(sel0); ack = 1'b1; end
            else ack = 1'b0;
        end
        while (got.size() < 5) got.push_back(7);
        for (int i = 0; i < 5; i++) chk($sformatf("rot_%0d", i), 32'(got[i]), 32'(i % 4));

        // Timeout on index 1 with index 2 also waiting.
        ack = 1'b0;
        do_reset();
        req = 4'b0110; vcnt = 0; seen_err = 1'b0;
        for (int c = 0; c < 40 && !seen_err; c++) begin
            step();
            if (err0) seen_err = 1'b1;
            else if (valid0) vcnt++;
        end
        chk("tmo_seen", 32'(seen_err), 32'd1);
        chk("tmo_len", 32'(vcnt), 32'd16);
        step();
        chk("tmo_err_pulse", 32'(err0), 32'd0);
        chk("tmo_next", 32'(sel0), 32'd2);

        // Ack and request drop together on the final budgeted cycle of index 3.
        do_reset();
        req = 4'b1000;
        step();
        chk("late_sel", 32'(sel0), 32'd3);
        for (int c = 0; c < 15; c++) step();
        ack = 1'b1; req = 4'b0000;
        step();
        chk("late_valid", 32'(valid0), 32'd0);
        chk("late_err", 32'(err0), 32'd0);
        ack = 1'b0; req = 4'b1001;
        step();
        step();
        chk("late_last", 32'(sel0), 32'd0);

        // Reset in the middle of a grant to index 2.
        do_reset();
        req = 4'b0100;
        step();
        chk("mid_sel", 32'(sel0), 32'd2);
        rst_n = 1'b0;
        step();
        chk("mid_valid", 32'(valid0), 32'd0);
        chk("mid_o", o0, 32'h0);
        chk("mid_err", 32'(err0), 32'd0);
        rst_n = 1'b1;
        step();
        chk("mid_regrant", 32'(valid0), 32'd1);
        chk("mid_regrant_sel", 32'(sel0), 32'd2);

        // Ack in IDLE is ignored.
        do_reset();
        ack = 1'b1;
        step();
        chk("idle_ack_err", 32'(err0), 32'd0);
        chk("idle_ack_valid", 32'(valid0), 32'd0);
        ack = 1'b0; req = 4'b0001;
        step();
        chk("idle_ack_grant", 32'(sel0), 32'd0);

        // Random traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            ack = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
